para_port_alloc_rr: RTL and testbench

PARA_PORT_ALLOC_RR -- requirements
Module: para_port_alloc_rr

---
 rtl/para_port_alloc_rr.sv | 120 ++++++++++++
 tb/tb_para_port_alloc_rr.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/para_port_alloc_rr.sv
// Parallel-lane port allocator: masks out ports claimed by other lanes, grants ports round-robin, and caps multicast forks by free flit slots.
// Latency is one cycle to a registered result; new requests are accepted only while the output register is empty or being drained.
module para_port_alloc_rr #(
    parameter int NUM_OUT    = 4,
    parameter int NUM_OTHERS = 3,
    parameter int IDX_W      = 3,
    parameter int FORK_MAX   = 5,
    localparam int PTR_W     = (NUM_OUT > 1) ? $clog2(NUM_OUT) : 1,
    localparam int CNT_W     = $clog2(NUM_OUT + 1)
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           in_valid,
    output logic                           in_ready,
    input  logic                           mc,
    input  logic                           treat_as_uc,
    input  logic [NUM_OUT-1:0]             ppv,
    input  logic [NUM_OUT*NUM_OTHERS-1:0]  ppv_others,
    input  logic [IDX_W-1:0]               num_flit_in,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [NUM_OUT-1:0]             apv_p,
    output logic [NUM_OUT-1:0]             ppv_p,
    output logic [CNT_W-1:0]               fork_cnt
);

    logic               out_valid_q, out_valid_d;
    logic [NUM_OUT-1:0] apv_q, apv_d;
    logic [NUM_OUT-1:0] ppv_q, ppv_d;
    logic [CNT_W-1:0]   fork_cnt_q, fork_cnt_d;
    logic [PTR_W-1:0]   rr_ptr_q, rr_ptr_d;

    logic [NUM_OUT-1:0] others_or;
    logic [NUM_OUT-1:0] mask;
    logic [NUM_OUT-1:0] grant;
    logic [PTR_W-1:0]   last_idx;
    logic [PTR_W-1:0]   idx;
    int                 budget;
    int                 limit;
    int                 grant_cnt;
    int                 scan_pos;
    int                 wrap_nxt;
    logic               accept;

    always_comb begin
        others_or = '0;
        for (int k = 0; k < NUM_OTHERS; k++) begin
            others_or = others_or | ppv_others[k*NUM_OUT +: NUM_OUT];
        end
        mask = ppv & ~others_or;
    end

    // Budget saturates at zero instead of wrapping when the router is already full.
    always_comb begin
        budget = (int'(num_flit_in) >= FORK_MAX) ? 0 : FORK_MAX - int'(num_flit_in);
        limit  = (mc && !treat_as_uc) ? budget : 1;
    end

    always_comb begin
        grant     = '0;
        grant_cnt = 0;
        last_idx  = rr_ptr_q;
        scan_pos  = 0;
        idx       = '0;
        for (int i = 0; i < NUM_OUT; i++) begin
            scan_pos = (int'(rr_ptr_q) + i) % NUM_OUT;
            idx      = PTR_W'(scan_pos);
            if (mask[idx] && (grant_cnt < limit)) begin
                grant[idx] = 1'b1;
                grant_cnt  = grant_cnt + 1;
                last_idx   = idx;
            end
        end
    end

    assign in_ready = !out_valid_q || out_ready;
    assign accept   = in_valid && in_ready;

    always_comb begin
        out_valid_d = out_valid_q;
        apv_d       = apv_q;
        ppv_d       = ppv_q;
        fork_cnt_d  = fork_cnt_q;
        rr_ptr_d    = rr_ptr_q;
        wrap_nxt    = (int'(last_idx) + 1) % NUM_OUT;
        if (accept) begin
            out_valid_d = 1'b1;
            apv_d       = grant;
            ppv_d       = ppv & ~grant;
            fork_cnt_d  = CNT_W'(grant_cnt);
            if (grant != '0) begin
                rr_ptr_d = PTR_W'(wrap_nxt);
            end
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_valid_q <= 1'b0;
            apv_q       <= '0;
            ppv_q       <= '0;
            fork_cnt_q  <= '0;
            rr_ptr_q    <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            apv_q       <= apv_d;
            ppv_q       <= ppv_d;
            fork_cnt_q  <= fork_cnt_d;
            rr_ptr_q    <= rr_ptr_d;
        end
    end

    assign out_valid = out_valid_q;
    assign apv_p     = apv_q;
    assign ppv_p     = ppv_q;
    assign fork_cnt  = fork_cnt_q;

endmodule

// File: tb/tb_para_port_alloc_rr.sv
// Bench for para_port_alloc_rr: directed scenarios plus random traffic against a queue-based reference model.
module tb_para_port_alloc_rr;

    localparam int N  = 4;
    localparam int O  = 3;
    localparam int IW = 3;
    localparam int FM = 5;

    logic            clk = 1'b0;
    logic            reset;
    logic            in_valid;
    logic            in_ready;
    logic            mc;
    logic            treat_as_uc;
    logic [N-1:0]    ppv;
    logic [N*O-1:0]  ppv_others;
    logic [IW-1:0]   num_flit_in;
    logic            out_valid;
    logic            out_ready;
    logic [N-1:0]    apv_p;
    logic [N-1:0]    ppv_p;
    logic [2:0]      fork_cnt;

    int n_chk  = 0;
    int n_fail = 0;

    logic         e_vld;
    logic [N-1:0] e_apv;
    logic [N-1:0] e_ppv;
    int           e_cnt;
    int           e_rr;

    para_port_alloc_rr #(.NUM_OUT(N), .NUM_OTHERS(O), .IDX_W(IW), .FORK_MAX(FM)) dut (
        .clk         (clk),
        .reset       (reset),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .mc          (mc),
        .treat_as_uc (treat_as_uc),
        .ppv         (ppv),
        .ppv_others  (ppv_others),
        .num_flit_in (num_flit_in),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .apv_p       (apv_p),
        .ppv_p       (ppv_p),
        .fork_cnt    (fork_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: list free ports in scan order, then take the first few.
    function automatic void ref_alloc(input int rr, input logic multi, input logic [N-1:0] p,
                                      input logic [N*O-1:0] po, input logic [IW-1:0] nf,
                                      output logic [N-1:0] g, output int nrr);
        logic [N-1:0] busy;
        int order[$];
        int budget;
        int take;
        busy = '0;
        for (int k = 0; k < O; k++) busy = busy | po[k*N +: N];
        for (int k = 0; k < N; k++) begin
            int b;
            b = (rr + k) % N;
            if (p[b] && !busy[b]) order.push_back(b);
        end
        budget = (int'(nf) >= FM) ? 0 : FM - int'(nf);
        if (!multi) take = (order.size() > 0) ? 1 : 0;
        else        take = (budget < order.size()) ? budget : order.size();
        g = '0;
        for (int j = 0; j < take; j++) g[order[j]] = 1'b1;
        nrr = (take > 0) ? (order[take-1] + 1) % N : rr;
    endfunction

    task automatic check_outs(input string tag);
        chk({tag, "_out_valid"}, out_valid, e_vld);
        chk({tag, "_apv_p"}, apv_p, e_apv);
        chk({tag, "_ppv_p"}, ppv_p, e_ppv);
        chk({tag, "_fork_cnt"}, fork_cnt, e_cnt);
        chk({tag, "_rr_ptr"}, dut.rr_ptr_q, e_rr);
    endtask

    task automatic cycle(input string tag, input logic v, input logic m_c, input logic uc,
                         input logic [N-1:0] p, input logic [N*O-1:0] po,
                         input logic [IW-1:0] nf, input logic ordy);
        logic         acc;
        logic [N-1:0] g;
        int           nrr;
        @(negedge clk);
        in_valid    = v;
        mc          = m_c;
        treat_as_uc = uc;
        ppv         = p;
        ppv_others  = po;
        num_flit_in = nf;
        out_ready   = ordy;
        #1;
        chk({tag, "_in_ready"}, in_ready, !e_vld || ordy);
        acc = v && (!e_vld || ordy);
        ref_alloc(e_rr, m_c && !uc, p, po, nf, g, nrr);
        @(posedge clk);
        #1;
        if (acc) begin
            e_vld = 1'b1;
            e_apv = g;
            e_ppv = p & ~g;
            e_cnt = $countones(g);
            e_rr  = nrr;
        end else if (ordy) begin
            e_vld = 1'b0;
        end
        check_outs(tag);
    endtask

    task automatic model_reset();
        e_vld = 1'b0;
        e_apv = '0;
        e_ppv = '0;
        e_cnt = 0;
        e_rr  = 0;
    endtask

    initial begin
        reset       = 1'b1;
        in_valid    = 1'b0;
        mc          = 1'b0;
        treat_as_uc = 1'b0;
        ppv         = '0;
        ppv_others  = '0;
        num_flit_in = '0;
        out_ready   = 1'b0;
        model_reset();
        #1;
        check_outs("rst");
        in_valid = 1'b1;
        ppv      = 4'b1111;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_no_accept", out_valid, 1'b0);
        @(negedge clk);
        reset = 1'b0;

        cycle("uc", 1, 0, 0, 4'b0110, '0, 3'd0, 1);
        chk("uc_apv_lit", apv_p, 4'b0010);
        chk("uc_ppv_lit", ppv_p, 4'b0100);
        chk("uc_cnt_lit", fork_cnt, 1);
        chk("uc_rr_lit", dut.rr_ptr_q, 2);

        cycle("to_rr0", 1, 0, 0, 4'b1000, '0, 3'd0, 1);
        cycle("budget", 1, 1, 0, 4'b1111, '0, 3'd3, 1);
        chk("budget_apv_lit", apv_p, 4'b0011);
        chk("budget_ppv_lit", ppv_p, 4'b1100);
        chk("budget_cnt_lit", fork_cnt, 2);
        chk("budget_rr_lit", dut.rr_ptr_q, 2);

        cycle("to_rr3", 1, 0, 0, 4'b0100, '0, 3'd0, 1);
        cycle("conflict", 1, 1, 0, 4'b1111, {4'b0000, 4'b0100, 4'b0001}, 3'd0, 1);
        chk("conflict_apv_lit", apv_p, 4'b1010);
        chk("conflict_ppv_lit", ppv_p, 4'b0101);
        chk("conflict_rr_lit", dut.rr_ptr_q, 2);
        cycle("wrap", 1, 0, 0, 4'b1001, '0, 3'd0, 1);
        chk("wrap_apv_lit", apv_p, 4'b1000);
        chk("wrap_rr_lit", dut.rr_ptr_q, 0);

        cycle("satur", 1, 1, 0, 4'b1011, '0, 3'd6, 1);
        chk("satur_apv_lit", apv_p, 4'b0000);
        chk("satur_ppv_lit", ppv_p, 4'b1011);
        chk("satur_cnt_lit", fork_cnt, 0);
        chk("satur_rr_lit", dut.rr_ptr_q, 0);

        cycle("uc_forced", 1, 1, 1, 4'b0111, '0, 3'd0, 1);
        cycle("load_bp", 1, 1, 0, 4'b1111, '0, 3'd1, 0);
        for (int i = 0; i < 3; i++) begin
            cycle("stall", 1, 0, 0, 4'b0001, '0, 3'd0, 0);
            chk("stall_in_ready_lit", in_ready, 1'b0);
        end
        cycle("bp_release", 1, 0, 0, 4'b0001, '0, 3'd0, 1);
        chk("bp_release_vld_lit", out_valid, 1'b1);
        chk("bp_release_apv_lit", apv_p, 4'b0001);
        cycle("drain", 0, 0, 0, 4'b1111, '0, 3'd0, 1);
        cycle("refill", 1, 1, 0, 4'b1110, '0, 3'd0, 0);

        @(negedge clk);
        #2;
        reset = 1'b1;
        #1;
        model_reset();
        check_outs("midrst");
        in_valid  = 1'b1;
        ppv       = 4'b1111;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("midrst_no_accept", out_valid, 1'b0);
        @(negedge clk);
        reset = 1'b0;
        cycle("post_rst", 1, 0, 0, 4'b1000, '0, 3'd0, 1);
        chk("post_rst_apv_lit", apv_p, 4'b1000);
        chk("post_rst_rr_lit", dut.rr_ptr_q, 0);

        for (int i = 0; i < 400; i++) begin
            cycle("rand", ($urandom_range(0, 3) != 0), 1'($urandom), ($urandom_range(0, 3) == 0),
                  N'($urandom), (N*O)'($urandom & $urandom & $urandom),
                  IW'($urandom_range(0, 7)), ($urandom_range(0, 3) != 0));
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
